// File: rtl/dpot_spi_ctrl.sv
// SPI write controller for three digital pots: 16-bit frame {command, wiper}, MSB first, mode 0.
// Optional DPOT_SHUTDOWN_EN adds input shdn, which selects the shutdown command byte 0x21.
module dpot_spi_ctrl #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [1:0] potSel,
  input  logic [7:0] wiper,
`ifdef DPOT_SHUTDOWN_EN
  input  logic       shdn,
`endif
  output logic       busy,
  output logic       done,
  output logic       selErr,
  output logic       csDpot1,
  output logic       csDpot2,
  output logic       csDpot3,
  output logic       sdiDpot,
  output logic       clkDpot
);

  localparam logic [7:0] LP_RELOAD = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_div;
  logic [3:0]  r_bit;
  logic        r_half;
  logic [15:0] r_frame;
  logic [1:0]  r_sel;
  logic        r_sel_err;
  logic        w_div_end;
  logic        w_accept;
  logic        w_active;
  logic [7:0]  w_cmd;

  assign w_div_end = (r_div == 8'd0);
  assign w_accept  = (r_state == IDLE) && start && (potSel != 2'd0);

`ifdef DPOT_SHUTDOWN_EN
  assign w_cmd = shdn ? 8'h21 : 8'h11;
`else
  assign w_cmd = 8'h11;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_next = SETUP;
      SETUP: if (w_div_end) w_next = SHIFT;
      SHIFT: if (w_div_end && r_half && (r_bit == 4'd0)) w_next = HOLD;
      HOLD:  if (w_div_end) w_next = DONE;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // r_bit only steps down at the end of a high half, so SETUP and HOLD see bits 15 and 0
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_div     <= '0;
      r_bit     <= '0;
      r_half    <= 1'b0;
      r_frame   <= '0;
      r_sel     <= '0;
      r_sel_err <= 1'b0;
    end else begin
      r_sel_err <= (r_state == IDLE) && start && (potSel == 2'd0);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_div   <= LP_RELOAD;
            r_bit   <= 4'd15;
            r_half  <= 1'b0;
            r_frame <= {w_cmd, wiper};
            r_sel   <= potSel;
          end
        end
        SETUP, HOLD: begin
          if (w_div_end) r_div <= LP_RELOAD;
          else           r_div <= r_div - 8'd1;
        end
        SHIFT: begin
          if (w_div_end) begin
            r_div  <= LP_RELOAD;
            r_half <= ~r_half;
            if (r_half && (r_bit != 4'd0)) r_bit <= r_bit - 4'd1;
          end else begin
            r_div <= r_div - 8'd1;
          end
        end
        DONE: begin
          r_div  <= '0;
          r_bit  <= '0;
          r_half <= 1'b0;
          r_sel  <= '0;
        end
        default: r_div <= '0;
      endcase
    end
  end

  always_comb begin
    w_active = (r_state == SETUP) || (r_state == SHIFT) || (r_state == HOLD);
    busy     = w_active;
    done     = (r_state == DONE);
    csDpot1  = !(w_active && (r_sel == 2'd1));
    csDpot2  = !(w_active && (r_sel == 2'd2));
    csDpot3  = !(w_active && (r_sel == 2'd3));
    clkDpot  = (r_state == SHIFT) && r_half;
    sdiDpot  = w_active ? r_frame[r_bit] : 1'b0;
  end

  assign selErr = r_sel_err;

endmodule
